// File: rtl/miner_pkg.sv
// Shared miner definitions: controller state encoding, word/frame geometry, start word.
// Pure declarations; no logic.
package miner_pkg;
  localparam int WORD_W         = 32;
  localparam int MIDSTATE_WORDS = 8;
  localparam int BLOCK_WORDS    = 16;
  localparam int MID_W          = WORD_W * MIDSTATE_WORDS;
  localparam int BLK_W          = WORD_W * BLOCK_WORDS;
  localparam logic [WORD_W-1:0] START_WORD_DEFAULT = 32'hB17C_0157;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_MID   = 3'b001,
    ST_REM   = 3'b010,
    ST_READY = 3'b011
  } ctrl_state_t;
endpackage

// File: rtl/job_loader_fsm_if.sv
// Job loader bus: host word stream, shift-timer flags, hasher handoff and loaded job.
// master = host/timer/hasher side, slave = the loader.
interface job_loader_fsm_if;
  import miner_pkg::*;

  logic                rx_valid;
  logic [WORD_W-1:0]   rx_data;
  logic                midstate_shifts_done;
  logic                remaining_shifts_done;
  logic                job_ready;
  ctrl_state_t         controller_state;
  logic                start_found;
  logic                shift_in_enable;
  logic [MID_W-1:0]    midstate;
  logic [BLK_W-1:0]    block_data;
  logic                job_valid;
  logic                load_error;

  modport master (
    output rx_valid, rx_data, midstate_shifts_done, remaining_shifts_done, job_ready,
    input  controller_state, start_found, shift_in_enable, midstate, block_data,
           job_valid, load_error
  );

  modport slave (
    input  rx_valid, rx_data, midstate_shifts_done, remaining_shifts_done, job_ready,
    output controller_state, start_found, shift_in_enable, midstate, block_data,
           job_valid, load_error
  );
endinterface

// File: rtl/job_loader_fsm_counter.sv
// Generic up-counter with synchronous clear (clear wins over increment).
// Count visible one cycle after the increment; no backpressure.
module job_loader_fsm_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_inc) r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;
endmodule

// File: rtl/miner_shift_timer.sv
// Counts accepted words across the MID and REM phases and flags the last word of each.
// Flags are combinational from the registered count; count clears outside MID/REM.
module miner_shift_timer
  import miner_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  ctrl_state_t i_state,
  input  logic        i_rx_valid,
  output logic        o_midstate_shifts_done,
  output logic        o_remaining_shifts_done
);
  logic [4:0] r_count;
  logic       w_active;

  assign w_active = (i_state == ST_MID) || (i_state == ST_REM);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)          r_count <= '0;
    else if (!w_active)  r_count <= '0;
    else if (i_rx_valid) r_count <= r_count + 5'(1);
  end

  assign o_midstate_shifts_done  = (i_state == ST_MID) && (r_count == 5'(MIDSTATE_WORDS - 1));
  assign o_remaining_shifts_done = (r_count == 5'(MIDSTATE_WORDS + BLOCK_WORDS - 1));
endmodule

// File: rtl/job_loader_fsm.sv
// Frames a host word stream into a SHA-256 midstate plus second block and hands it to the hasher.
// Words shift in the cycle they arrive; job held in READY until job_ready, rx ignored meanwhile.
module job_loader_fsm
  import miner_pkg::*;
#(
  parameter logic [WORD_W-1:0] START_WORD = START_WORD_DEFAULT,
  parameter int                GAP_LIMIT  = 1023
) (
  input logic              clk,
  input logic              n_rst,
  job_loader_fsm_if.slave  bus
);
  localparam int GAP_W = $clog2(GAP_LIMIT + 1);

  ctrl_state_t       r_state, w_next_state;
  logic [MID_W-1:0]  r_midstate;
  logic [BLK_W-1:0]  r_block_data;
  logic              r_load_error;
  logic [GAP_W-1:0]  w_gap_count;
  logic              w_start_found, w_mid_shift, w_rem_shift, w_clear_job;
  logic              w_abort, w_gap_inc, w_gap_clr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= ST_IDLE;
      r_load_error <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_load_error <= w_abort;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_start_found = 1'b0;
    w_mid_shift   = 1'b0;
    w_rem_shift   = 1'b0;
    w_clear_job   = 1'b0;
    w_abort       = 1'b0;
    w_gap_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start_found = bus.rx_valid && (bus.rx_data == START_WORD);
        if (w_start_found) begin
          w_next_state = ST_MID;
          w_clear_job  = 1'b1;
        end
      end
      ST_MID: begin
        // Midstate words arrive as an unbroken burst; any hole abandons the frame.
        if (bus.rx_valid) begin
          w_mid_shift = 1'b1;
          if (bus.midstate_shifts_done) w_next_state = ST_REM;
        end else begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_REM: begin
        // A word arriving after exactly GAP_LIMIT idle cycles is still accepted.
        if (bus.rx_valid) begin
          w_rem_shift = 1'b1;
          if (bus.remaining_shifts_done) w_next_state = ST_READY;
        end else if (w_gap_count == GAP_W'(GAP_LIMIT)) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_gap_inc = 1'b1;
        end
      end
      ST_READY: begin
        if (bus.job_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_gap_clr = (r_state != ST_REM) || w_rem_shift;

  job_loader_fsm_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clr   (w_gap_clr),
    .i_inc   (w_gap_inc),
    .o_count (w_gap_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_midstate   <= '0;
      r_block_data <= '0;
    end else if (w_clear_job) begin
      r_midstate   <= '0;
      r_block_data <= '0;
    end else begin
      if (w_mid_shift) r_midstate   <= {r_midstate[MID_W-WORD_W-1:0], bus.rx_data};
      if (w_rem_shift) r_block_data <= {r_block_data[BLK_W-WORD_W-1:0], bus.rx_data};
    end
  end

  assign bus.controller_state = r_state;
  assign bus.start_found      = w_start_found;
  assign bus.shift_in_enable  = w_rem_shift;
  assign bus.midstate         = r_midstate;
  assign bus.block_data       = r_block_data;
  assign bus.job_valid        = (r_state == ST_READY);
  assign bus.load_error       = r_load_error;
endmodule

// File: tb/tb_job_loader_fsm.sv
// Bench for job_loader_fsm with the shift timer in-loop, checked against a queue-based frame model.
module tb_job_loader_fsm;
  import miner_pkg::*;

  localparam int          GAP = 8;
  localparam logic [31:0] SW  = START_WORD_DEFAULT;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  job_loader_fsm_if bus();

  job_loader_fsm #(.START_WORD(SW), .GAP_LIMIT(GAP)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  miner_shift_timer u_timer (
    .clk                     (clk),
    .n_rst                   (n_rst),
    .i_state                 (bus.controller_state),
    .i_rx_valid              (bus.rx_valid),
    .o_midstate_shifts_done  (bus.midstate_shifts_done),
    .o_remaining_shifts_done (bus.remaining_shifts_done)
  );

  int checks = 0;
  int errors = 0;
  int lerr_cnt = 0;
  int jv_cnt = 0;

  // Reference: phase 0 waiting, 1 collecting midstate, 2 collecting block, 3 job offered.
  int          m_phase;
  logic [31:0] m_words[$];
  int          m_idle;
  logic        m_err;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_words.delete();
    m_idle = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic rdy);
    m_err = 1'b0;
    case (m_phase)
      0: if (v && d == SW) begin m_phase = 1; m_words.delete(); end
      1: if (!v) begin
           m_err = 1'b1; m_phase = 0;
         end else begin
           m_words.push_back(d);
           if (m_words.size() == 8) begin m_phase = 2; m_idle = 0; end
         end
      2: if (v) begin
           m_words.push_back(d); m_idle = 0;
           if (m_words.size() == 24) m_phase = 3;
         end else if (m_idle >= GAP) begin
           m_err = 1'b1; m_phase = 0;
         end else begin
           m_idle++;
         end
      default: if (rdy) m_phase = 0;
    endcase
  endtask

  function automatic logic [255:0] exp_mid();
    logic [255:0] r = '0;
    int n = (m_words.size() < 8) ? m_words.size() : 8;
    for (int i = 0; i < n; i++) r[32*(n-1-i) +: 32] = m_words[i];
    return r;
  endfunction

  function automatic logic [511:0] exp_blk();
    logic [511:0] r = '0;
    int n = (m_words.size() > 8) ? m_words.size() - 8 : 0;
    for (int i = 0; i < n; i++) r[32*(n-1-i) +: 32] = m_words[8+i];
    return r;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] d, input logic rdy = 1'b0);
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.job_ready = rdy;
    @(negedge clk);
    chk("state", 512'(bus.controller_state), 512'(m_phase));
    chk("job_valid", 512'(bus.job_valid), 512'(m_phase == 3));
    chk("load_error", 512'(bus.load_error), 512'(m_err));
    chk("start_found", 512'(bus.start_found), 512'(m_phase == 0 && v && d == SW));
    chk("shift_in_enable", 512'(bus.shift_in_enable), 512'(m_phase == 2 && v));
    chk("midstate", 512'(bus.midstate), 512'(exp_mid()));
    chk("block_data", bus.block_data, exp_blk());
    @(posedge clk);
    model_edge(v, d, rdy);
    #1;
    lerr_cnt += int'(bus.load_error);
    jv_cnt   += int'(bus.job_valid);
  endtask

  task automatic run_frame(input int drop_at, input int stall_at, input int max_gap,
                           input logic [31:0] w[24]);
    cyc(1'b1, SW);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at) begin cyc(1'b0, $urandom); return; end
      cyc(1'b1, w[i]);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        repeat (GAP + 4) cyc(1'b0, $urandom);
        return;
      end
      repeat ($urandom_range(0, max_gap)) cyc(1'b0, $urandom);
      cyc(1'b1, w[8+i]);
    end
  endtask

  task automatic handoff(input int hold);
    repeat (hold) cyc(1'($urandom_range(0, 1)), $urandom, 1'b0);
    cyc(1'b0, $urandom, 1'b1);
  endtask

  initial begin
    logic [31:0]  w[24];
    logic [255:0] c_mid;
    logic [511:0] c_blk;
    int mode, drop, stall;

    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.job_ready = 1'b0;
    model_reset();
    #1 n_rst = 1'b0;
    #1;
    chk("rst_state", 512'(bus.controller_state), 512'(0));
    chk("rst_mid", 512'(bus.midstate), 512'(0));
    chk("rst_blk", bus.block_data, 512'(0));
    chk("rst_job_valid", 512'(bus.job_valid), 512'(0));
    chk("rst_load_error", 512'(bus.load_error), 512'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); model_edge(1'b0, '0, 1'b0); #1;

    for (int i = 0; i < 4; i++) cyc(1'b1, SW ^ 32'(i + 1));

    // Clean frame and handoff
    for (int i = 0; i < 8; i++)  w[i]     = 32'(i + 1);
    for (int i = 0; i < 16; i++) w[8 + i] = 32'h10 + 32'(i);
    run_frame(-1, -1, 5, w);
    for (int i = 0; i < 8; i++)  c_mid[255 - 32*i -: 32] = 32'(i + 1);
    for (int i = 0; i < 16; i++) c_blk[511 - 32*i -: 32] = 32'h10 + 32'(i);
    chk("clean_mid", 512'(bus.midstate), 512'(c_mid));
    chk("clean_blk", bus.block_data, c_blk);
    chk("clean_job_valid", 512'(bus.job_valid), 512'(1));
    jv_cnt = 0;
    repeat (5) cyc(1'($urandom_range(0, 1)), $urandom, 1'b0);
    chk("handoff_hold_cycles", 512'(jv_cnt), 512'(5));
    cyc(1'b0, '0, 1'b1);
    chk("handoff_idle", 512'(bus.controller_state), 512'(0));
    chk("handoff_jv_drop", 512'(bus.job_valid), 512'(0));
    chk("handoff_keep_mid", 512'(bus.midstate), 512'(c_mid));
    chk("handoff_keep_blk", bus.block_data, c_blk);
    repeat (3) cyc(1'b0, $urandom);

    // Midstate underflow after the 3rd word, then a clean frame
    for (int i = 0; i < 24; i++) w[i] = $urandom;
    lerr_cnt = 0;
    run_frame(3, -1, 0, w);
    chk("under_err", 512'(bus.load_error), 512'(1));
    chk("under_state", 512'(bus.controller_state), 512'(0));
    cyc(1'b0, $urandom);
    chk("under_err_one_cycle", 512'(bus.load_error), 512'(0));
    chk("under_err_count", 512'(lerr_cnt), 512'(1));
    for (int i = 0; i < 24; i++) w[i] = $urandom;
    run_frame(-1, -1, 3, w);
    for (int i = 0; i < 8; i++) c_mid[255 - 32*i -: 32] = w[i];
    chk("under_recover_mid", 512'(bus.midstate), 512'(c_mid));
    handoff(1);

    // Gap timeout after the 5th block word
    for (int i = 0; i < 24; i++) w[i] = $urandom;
    lerr_cnt = 0; jv_cnt = 0;
    run_frame(-1, 5, 2, w);
    chk("gap_err_count", 512'(lerr_cnt), 512'(1));
    chk("gap_no_job", 512'(jv_cnt), 512'(0));
    chk("gap_state", 512'(bus.controller_state), 512'(0));

    // Async reset in the middle of block word 10
    cyc(1'b1, SW);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(i));
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'h200 + 32'(i));
    bus.rx_valid = 1'b1; bus.rx_data = 32'h209;
    #2 n_rst = 1'b0;
    #1;
    chk("arst_state", 512'(bus.controller_state), 512'(0));
    chk("arst_mid", 512'(bus.midstate), 512'(0));
    chk("arst_blk", bus.block_data, 512'(0));
    chk("arst_job_valid", 512'(bus.job_valid), 512'(0));
    chk("arst_shift_en", 512'(bus.shift_in_enable), 512'(0));
    model_reset();
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); model_edge(1'b0, '0, 1'b0); #1;
    for (int i = 0; i < 24; i++) w[i] = $urandom;
    run_frame(-1, -1, 4, w);
    for (int i = 0; i < 16; i++) c_blk[511 - 32*i -: 32] = w[8 + i];
    chk("arst_recover_blk", bus.block_data, c_blk);
    handoff(2);

    // Start word as midstate word 4
    for (int i = 0; i < 24; i++) w[i] = $urandom;
    w[3] = SW;
    run_frame(-1, -1, 2, w);
    chk("sw_data_slot", 512'(bus.midstate[159:128]), 512'(SW));
    chk("sw_data_ready", 512'(bus.controller_state), 512'(3));
    handoff(0);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      mode  = int'($urandom_range(0, 3));
      drop  = (mode == 0) ? int'($urandom_range(0, 7)) : -1;
      stall = (mode == 1) ? int'($urandom_range(0, 15)) : -1;
      for (int i = 0; i < 24; i++) w[i] = $urandom;
      if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 23)] = SW;
      repeat ($urandom_range(0, 3)) cyc(1'b0, $urandom);
      run_frame(drop, stall, 5, w);
      if (mode > 1) handoff(int'($urandom_range(0, 4)));
    end
    cyc(1'b0, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
